// File: rtl/jtag_ram_arbiter_if.sv
// Bus bundle between the two debug RAM requesters, the arbiter and the RAM port.
//   a_*      : port A (JTAG bridge) request/response, read or write
//   b_*      : port B (LED/dip display) request/response, read only
//   ram_*    : single synchronous RAM port; ram_rdata valid the cycle after ram_en
// Modport master is the requester/RAM side, slave is the arbiter.
interface jtag_ram_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              a_valid;
    logic              a_ready;
    logic              a_we;
    logic [31:0]       a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_rsp_valid;
    logic [DATA_W-1:0] a_rsp_rdata;
    logic              a_rsp_err;

    logic              b_valid;
    logic              b_ready;
    logic [31:0]       b_addr;
    logic              b_rsp_valid;
    logic [DATA_W-1:0] b_rsp_rdata;
    logic              b_rsp_err;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        output a_valid, a_we, a_addr, a_wdata, b_valid, b_addr, ram_rdata,
        input  a_ready, a_rsp_valid, a_rsp_rdata, a_rsp_err,
        input  b_ready, b_rsp_valid, b_rsp_rdata, b_rsp_err,
        input  ram_en, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        input  a_valid, a_we, a_addr, a_wdata, b_valid, b_addr, ram_rdata,
        output a_ready, a_rsp_valid, a_rsp_rdata, a_rsp_err,
        output b_ready, b_rsp_valid, b_rsp_rdata, b_rsp_err,
        output ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/jtag_ram_arbiter.sv
// Round-robin arbiter sharing one port of the 512x32 debug block RAM between
// the JTAG bridge (port A, read/write) and the display reader (port B, read only).
// Each transaction takes IDLE -> ISSUE -> CAPTURE -> IDLE: accepted in IDLE (T),
// RAM strobes driven in ISSUE (T+1), one-cycle response in CAPTURE (T+2).
// Out-of-range addresses and writes while the write permit is off are answered
// with an error and never reach the RAM.
// Ports:
//   clk_p   : system clock, rising edge
//   rstn    : asynchronous active-low reset
//   wr_en   : global write permit (WR switch), sampled at accept
//   bus     : requester A/B handshakes and RAM port (jtag_ram_arbiter_if.slave)
//   cnt_a, cnt_b : accepted requests per port, saturating
//   cnt_err : error responses on either port, saturating
module jtag_ram_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic             clk_p,
    input  logic             rstn,
    input  logic             wr_en,
    jtag_ram_arbiter_if.slave bus,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b,
    output logic [CNT_W-1:0] cnt_err
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;

    logic [1:0]        state_r;
    logic              last_b_r;     // 1: port B won the last grant
    logic              gnt_b_r;      // port of the transaction in flight
    logic              we_r;
    logic              range_err_r;
    logic              wr_err_r;
    logic              good_rd_r;

    logic              ram_en_r;
    logic              ram_we_r;
    logic [ADDR_W-1:0] ram_addr_r;
    logic [DATA_W-1:0] ram_wdata_r;

    logic              a_rsp_valid_r;
    logic              a_rsp_err_r;
    logic              b_rsp_valid_r;
    logic              b_rsp_err_r;

    logic [CNT_W-1:0]  cnt_a_r;
    logic [CNT_W-1:0]  cnt_b_r;
    logic [CNT_W-1:0]  cnt_err_r;

    logic              a_ready_s;
    logic              b_ready_s;
    logic              accept_s;
    logic [31:0]       req_addr_s;
    logic              req_we_s;
    logic [DATA_W-1:0] req_wdata_s;
    logic              req_range_err_s;
    logic              req_wr_err_s;

    // Saturating increment: all-ones sticks instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    // Grant selection in IDLE; on a tie the port that did not win last time goes.
    always_comb begin
        a_ready_s = 1'b0;
        b_ready_s = 1'b0;
        if (state_r == IDLE) begin
            if (bus.a_valid && bus.b_valid) begin
                a_ready_s = last_b_r;
                b_ready_s = ~last_b_r;
            end else begin
                a_ready_s = bus.a_valid;
                b_ready_s = bus.b_valid;
            end
        end else begin
            a_ready_s = 1'b0;
            b_ready_s = 1'b0;
        end
    end

    // Mux the granted request; port B never writes.
    always_comb begin
        accept_s        = a_ready_s | b_ready_s;
        req_addr_s      = b_ready_s ? bus.b_addr : bus.a_addr;
        req_we_s        = a_ready_s & bus.a_we;
        req_wdata_s     = req_we_s ? bus.a_wdata : {DATA_W{1'b0}};
        req_range_err_s = |req_addr_s[31:ADDR_W];
        req_wr_err_s    = req_we_s & ~wr_en;
    end

    // Transaction FSM and per-transaction attributes latched at accept.
    always_ff @(posedge clk_p or negedge rstn) begin
        if (!rstn) begin
            state_r     <= IDLE;
            last_b_r    <= 1'b1;
            gnt_b_r     <= 1'b0;
            we_r        <= 1'b0;
            range_err_r <= 1'b0;
            wr_err_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_r     <= ISSUE;
                        last_b_r    <= b_ready_s;
                        gnt_b_r     <= b_ready_s;
                        we_r        <= req_we_s;
                        range_err_r <= req_range_err_s;
                        wr_err_r    <= req_wr_err_s;
                    end else begin
                        state_r     <= IDLE;
                    end
                end
                ISSUE:   state_r <= CAPTURE;
                CAPTURE: state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    // RAM strobes: live only for the ISSUE cycle, suppressed for error transactions.
    always_ff @(posedge clk_p or negedge rstn) begin
        if (!rstn) begin
            ram_en_r    <= 1'b0;
            ram_we_r    <= 1'b0;
            ram_addr_r  <= {ADDR_W{1'b0}};
            ram_wdata_r <= {DATA_W{1'b0}};
        end else if ((state_r == IDLE) && accept_s) begin
            ram_en_r    <= ~(req_range_err_s | req_wr_err_s);
            ram_we_r    <= req_we_s & ~req_range_err_s & ~req_wr_err_s;
            ram_addr_r  <= req_addr_s[ADDR_W-1:0];
            ram_wdata_r <= req_wdata_s;
        end else begin
            ram_en_r    <= 1'b0;
            ram_we_r    <= 1'b0;
            ram_addr_r  <= {ADDR_W{1'b0}};
            ram_wdata_r <= {DATA_W{1'b0}};
        end
    end

    // Response flags for the CAPTURE cycle.
    always_ff @(posedge clk_p or negedge rstn) begin
        if (!rstn) begin
            a_rsp_valid_r <= 1'b0;
            a_rsp_err_r   <= 1'b0;
            b_rsp_valid_r <= 1'b0;
            b_rsp_err_r   <= 1'b0;
            good_rd_r     <= 1'b0;
        end else if (state_r == ISSUE) begin
            a_rsp_valid_r <= ~gnt_b_r;
            a_rsp_err_r   <= ~gnt_b_r & (range_err_r | wr_err_r);
            b_rsp_valid_r <= gnt_b_r;
            b_rsp_err_r   <= gnt_b_r & (range_err_r | wr_err_r);
            good_rd_r     <= ~we_r & ~range_err_r & ~wr_err_r;
        end else begin
            a_rsp_valid_r <= 1'b0;
            a_rsp_err_r   <= 1'b0;
            b_rsp_valid_r <= 1'b0;
            b_rsp_err_r   <= 1'b0;
            good_rd_r     <= 1'b0;
        end
    end

    // Debug counters: accepts counted at accept, errors alongside the response.
    always_ff @(posedge clk_p or negedge rstn) begin
        if (!rstn) begin
            cnt_a_r   <= {CNT_W{1'b0}};
            cnt_b_r   <= {CNT_W{1'b0}};
            cnt_err_r <= {CNT_W{1'b0}};
        end else begin
            if (a_ready_s) begin
                cnt_a_r <= sat_inc(cnt_a_r);
            end else begin
                cnt_a_r <= cnt_a_r;
            end
            if (b_ready_s) begin
                cnt_b_r <= sat_inc(cnt_b_r);
            end else begin
                cnt_b_r <= cnt_b_r;
            end
            if ((state_r == ISSUE) && (range_err_r || wr_err_r)) begin
                cnt_err_r <= sat_inc(cnt_err_r);
            end else begin
                cnt_err_r <= cnt_err_r;
            end
        end
    end

    assign bus.a_ready   = a_ready_s;
    assign bus.b_ready   = b_ready_s;
    assign bus.ram_en    = ram_en_r;
    assign bus.ram_we    = ram_we_r;
    assign bus.ram_addr  = ram_addr_r;
    assign bus.ram_wdata = ram_wdata_r;

    // Read data arrives from the RAM during CAPTURE itself, so it is steered
    // straight through to the granted port rather than re-registered.
    assign bus.a_rsp_valid = a_rsp_valid_r;
    assign bus.a_rsp_err   = a_rsp_err_r;
    assign bus.a_rsp_rdata = (a_rsp_valid_r && good_rd_r) ? bus.ram_rdata : {DATA_W{1'b0}};
    assign bus.b_rsp_valid = b_rsp_valid_r;
    assign bus.b_rsp_err   = b_rsp_err_r;
    assign bus.b_rsp_rdata = (b_rsp_valid_r && good_rd_r) ? bus.ram_rdata : {DATA_W{1'b0}};

    assign cnt_a   = cnt_a_r;
    assign cnt_b   = cnt_b_r;
    assign cnt_err = cnt_err_r;

endmodule

// File: tb/tb_jtag_ram_arbiter.sv
// Bench for jtag_ram_arbiter: directed requests, a behavioural RAM, and a
// transaction-level reference model compared against the DUT every cycle.
module tb_jtag_ram_arbiter;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    logic             clk_p = 1'b0;
    logic             rstn;
    logic             wr_en;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;
    logic [CNT_W-1:0] cnt_err;

    int n_checks = 0;
    int n_errors = 0;

    jtag_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    jtag_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk_p   (clk_p),
        .rstn    (rstn),
        .wr_en   (wr_en),
        .bus     (bus),
        .cnt_a   (cnt_a),
        .cnt_b   (cnt_b),
        .cnt_err (cnt_err)
    );

    always #5 clk_p = ~clk_p;

    function automatic logic [31:0] init_word(input int i);
        return 32'hA5A5_0000 | i;
    endfunction

    // Behavioural RAM: read-first, data out the cycle after ram_en.
    logic [31:0] ram_mem [0:511];
    bit ram_init_done = 1'b0;
    always @(posedge clk_p) begin
        if (!ram_init_done) begin
            for (int i = 0; i < 512; i++) ram_mem[i] <= init_word(i);
            ram_init_done <= 1'b1;
        end
        if (bus.ram_en) begin
            if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
            bus.ram_rdata <= ram_mem[bus.ram_addr];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic [31:0] exp_mem [0:511];
    int          m_stage;           // cycles since accept, 0 = free
    bit          m_last_b;
    bit          m_b, m_we, m_err;
    logic [31:0] m_addr, m_wdata;
    logic [15:0] m_cnt_a, m_cnt_b, m_cnt_err;

    task automatic model_reset();
        m_stage = 0; m_last_b = 1'b1;
        m_cnt_a = 16'h0; m_cnt_b = 16'h0; m_cnt_err = 16'h0;
    endtask

    task automatic compare_loop();
        bit          e_ar, e_br, e_en, e_we, e_av, e_ae, e_bv, e_be;
        logic [8:0]  e_addr;
        logic [31:0] e_wd, e_ard, e_brd;
        forever begin
            @(negedge clk_p);
            e_ar = 0; e_br = 0; e_en = 0; e_we = 0; e_addr = 9'h0; e_wd = 32'h0;
            e_av = 0; e_ae = 0; e_ard = 32'h0; e_bv = 0; e_be = 0; e_brd = 32'h0;
            if (!rstn) model_reset();
            if (rstn && m_stage == 0) begin
                if (bus.a_valid && bus.b_valid) begin
                    if (m_last_b) e_ar = 1; else e_br = 1;
                end else if (bus.a_valid) e_ar = 1;
                else if (bus.b_valid) e_br = 1;
            end else if (rstn && m_stage == 1) begin
                e_en = !m_err;
                e_we = m_we && !m_err;
                e_addr = m_addr[8:0];
                e_wd = m_we ? m_wdata : 32'h0;
            end else if (rstn && m_stage == 2) begin
                if (m_b) begin
                    e_bv = 1; e_be = m_err;
                    e_brd = (!m_err && !m_we) ? exp_mem[m_addr[8:0]] : 32'h0;
                end else begin
                    e_av = 1; e_ae = m_err;
                    e_ard = (!m_err && !m_we) ? exp_mem[m_addr[8:0]] : 32'h0;
                end
            end
            check("a_ready", bus.a_ready, e_ar);
            check("b_ready", bus.b_ready, e_br);
            check("ram_en", bus.ram_en, e_en);
            check("ram_we", bus.ram_we, e_we);
            check("ram_addr", bus.ram_addr, e_addr);
            check("ram_wdata", bus.ram_wdata, e_wd);
            check("a_rsp_valid", bus.a_rsp_valid, e_av);
            check("a_rsp_err", bus.a_rsp_err, e_ae);
            check("a_rsp_rdata", bus.a_rsp_rdata, e_ard);
            check("b_rsp_valid", bus.b_rsp_valid, e_bv);
            check("b_rsp_err", bus.b_rsp_err, e_be);
            check("b_rsp_rdata", bus.b_rsp_rdata, e_brd);
            check("cnt_a", cnt_a, m_cnt_a);
            check("cnt_b", cnt_b, m_cnt_b);
            check("cnt_err", cnt_err, m_cnt_err);
            if (rstn) begin
                if (m_stage == 0) begin
                    if (e_ar || e_br) begin
                        m_b = e_br;
                        m_we = e_ar && bus.a_we;
                        m_addr = e_br ? bus.b_addr : bus.a_addr;
                        m_wdata = bus.a_wdata;
                        m_err = (m_addr >= 32'd512) || (m_we && !wr_en);
                        m_last_b = e_br;
                        if (e_br) begin
                            if (m_cnt_b != 16'hFFFF) m_cnt_b = m_cnt_b + 16'd1;
                        end else begin
                            if (m_cnt_a != 16'hFFFF) m_cnt_a = m_cnt_a + 16'd1;
                        end
                        m_stage = 1;
                    end
                end else if (m_stage == 1) begin
                    if (m_err && m_cnt_err != 16'hFFFF) m_cnt_err = m_cnt_err + 16'd1;
                    if (m_we && !m_err) exp_mem[m_addr[8:0]] = m_wdata;
                    m_stage = 2;
                end else begin
                    m_stage = 0;
                end
            end
        end
    endtask

    // One request on a port; returns RAM strobes at T+1 and the response at T+2.
    task automatic do_req(input bit port_b, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata,
                          output bit iss_en, output bit iss_we, output logic [8:0] iss_addr,
                          output bit rsp_v, output bit rsp_err, output logic [31:0] rsp_rd);
        int waited = 0;
        bit got = 0;
        @(posedge clk_p); #1;
        if (port_b) begin
            bus.b_valid = 1'b1; bus.b_addr = addr;
        end else begin
            bus.a_valid = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata;
        end
        while (!got && waited < 20) begin
            @(negedge clk_p);
            got = port_b ? bus.b_ready : bus.a_ready;
            waited++;
        end
        if (!got) begin
            n_checks++; n_errors++;
            $display("FAIL accept_timeout: got no ready expected ready within 20 cycles");
        end
        @(posedge clk_p); #1;
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        @(negedge clk_p);
        iss_en = bus.ram_en; iss_we = bus.ram_we; iss_addr = bus.ram_addr;
        @(negedge clk_p);
        rsp_v   = port_b ? bus.b_rsp_valid : bus.a_rsp_valid;
        rsp_err = port_b ? bus.b_rsp_err : bus.a_rsp_err;
        rsp_rd  = port_b ? bus.b_rsp_rdata : bus.a_rsp_rdata;
        @(posedge clk_p); #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          en, we, v, err;
        logic [8:0]  ad;
        logic [31:0] rd;
        logic [15:0] a0, b0, da, db;
        int          grants, waited;

        rstn = 1'b0; wr_en = 1'b0;
        bus.a_valid = 1'b0; bus.a_we = 1'b0; bus.a_addr = 32'h0; bus.a_wdata = 32'h0;
        bus.b_valid = 1'b0; bus.b_addr = 32'h0;
        for (int i = 0; i < 512; i++) exp_mem[i] = init_word(i);
        model_reset();
        fork
            compare_loop();
        join_none

        // 1: reset, then write 5
        repeat (3) @(posedge clk_p);
        #1 rstn = 1'b1; wr_en = 1'b1;
        do_req(1'b0, 1'b1, 32'd5, 32'hDEADBEEF, en, we, ad, v, err, rd);
        check("t1_ram_en", en, 1'b1);
        check("t1_ram_we", we, 1'b1);
        check("t1_ram_addr", ad, 9'd5);
        check("t1_rsp_valid", v, 1'b1);
        check("t1_rsp_err", err, 1'b0);
        check("t1_cnt_a", cnt_a, 16'd1);

        // 2: read back 5
        do_req(1'b0, 1'b0, 32'd5, 32'h0, en, we, ad, v, err, rd);
        check("t2_rdata", rd, 32'hDEADBEEF);
        check("t2_err", err, 1'b0);

        // 3: both requesters valid continuously for 8 grants
        @(posedge clk_p); #1;
        a0 = cnt_a; b0 = cnt_b;
        bus.a_valid = 1'b1; bus.a_we = 1'b0; bus.a_addr = 32'd5;
        bus.b_valid = 1'b1; bus.b_addr = 32'd10;
        grants = 0; waited = 0;
        while (grants < 8 && waited < 100) begin
            @(negedge clk_p);
            if (bus.a_ready || bus.b_ready) grants++;
            waited++;
        end
        if (grants < 8) begin
            n_checks++; n_errors++;
            $display("FAIL t3_timeout: got %0d grants expected 8", grants);
        end
        @(posedge clk_p); #1;
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        repeat (3) @(posedge clk_p);
        #1;
        da = cnt_a - a0; db = cnt_b - b0;
        check("t3_cnt_a_delta", da, 16'd4);
        check("t3_cnt_b_delta", db, 16'd4);

        // 4: out-of-range on both ports
        do_req(1'b0, 1'b1, 32'h200, 32'h1234_5678, en, we, ad, v, err, rd);
        check("t4_ram_en", en, 1'b0);
        check("t4_a_err", err, 1'b1);
        check("t4_a_rdata", rd, 32'h0);
        check("t4_cnt_err1", cnt_err, 16'd1);
        do_req(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, en, we, ad, v, err, rd);
        check("t4_b_valid", v, 1'b1);
        check("t4_b_err", err, 1'b1);
        check("t4_cnt_err2", cnt_err, 16'd2);

        // 5: write with permit off is rejected and leaves RAM intact
        wr_en = 1'b0;
        do_req(1'b0, 1'b1, 32'd7, 32'hCAFE_F00D, en, we, ad, v, err, rd);
        check("t5_ram_we", we, 1'b0);
        check("t5_err", err, 1'b1);
        wr_en = 1'b1;
        do_req(1'b0, 1'b0, 32'd7, 32'h0, en, we, ad, v, err, rd);
        check("t5_rdata", rd, 32'hA5A5_0007);
        check("t5_rd_err", err, 1'b0);

        // 6: reset during ISSUE of a read
        @(posedge clk_p); #1;
        bus.a_valid = 1'b1; bus.a_we = 1'b0; bus.a_addr = 32'd9;
        @(negedge clk_p);
        check("t6_accept", bus.a_ready, 1'b1);
        @(posedge clk_p); #1;
        bus.a_valid = 1'b0; rstn = 1'b0;
        #1 check("t6_ram_en_drop", bus.ram_en, 1'b0);
        repeat (2) @(posedge clk_p);
        #1 rstn = 1'b1;
        repeat (3) @(negedge clk_p);
        do_req(1'b0, 1'b0, 32'd5, 32'h0, en, we, ad, v, err, rd);
        check("t6_after_rdata", rd, 32'hDEADBEEF);
        check("t6_after_cnt_a", cnt_a, 16'd1);

        // Saturation: pin cnt_a at all-ones, further accepts keep it there
        @(posedge clk_p); #1;
        force dut.cnt_a_r = 16'hFFFF;
        m_cnt_a = 16'hFFFF;
        @(posedge clk_p); #1;
        release dut.cnt_a_r;
        do_req(1'b0, 1'b0, 32'd3, 32'h0, en, we, ad, v, err, rd);
        do_req(1'b0, 1'b1, 32'd4, 32'h0BAD_CAFE, en, we, ad, v, err, rd);
        check("t6_sat_cnt_a", cnt_a, 16'hFFFF);

        repeat (2) @(posedge clk_p);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
